// File: rtl/data_sram_arbiter.sv
// Shares the single data_sram port between the two issue slots of a dual-issued pair.
// A pair is serialised i1 then i2, costing one stall cycle; i1 load data is held for MEM.
module data_sram_arbiter #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               hold,
    input  logic               req_i1,
    input  logic               req_i2,
    input  logic               ex_i1,
    input  logic               ex_i2,
    input  logic [3:0]         wen_i1,
    input  logic [3:0]         wen_i2,
    input  logic [ADDR_WD-1:0] addr_i1,
    input  logic [ADDR_WD-1:0] addr_i2,
    input  logic [DATA_WD-1:0] wdata_i1,
    input  logic [DATA_WD-1:0] wdata_i2,
    input  logic [DATA_WD-1:0] data_sram_rdata,
    output logic               data_sram_en,
    output logic [3:0]         data_sram_wen,
    output logic [ADDR_WD-1:0] data_sram_addr,
    output logic [DATA_WD-1:0] data_sram_wdata,
    output logic               stallreq,
    output logic [DATA_WD-1:0] rdata_i1,
    output logic [DATA_WD-1:0] rdata_i2
);

    typedef enum logic {IDLE, SECOND} state_t;

    state_t             state;
    logic               pair_r;
    logic [DATA_WD-1:0] hold_r;
    logic [3:0]         buf_wen;
    logic [ADDR_WD-1:0] buf_addr;
    logic [DATA_WD-1:0] buf_wdata;

    logic go1;
    logic go2;

    // An older exception in i1 also kills the younger slot.
    assign go1 = req_i1 & ~ex_i1;
    assign go2 = req_i2 & ~ex_i2 & ~ex_i1;

    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        stallreq        = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && !flush && !hold) begin
                    if (go1) begin
                        data_sram_en    = 1'b1;
                        data_sram_wen   = wen_i1;
                        data_sram_addr  = addr_i1;
                        data_sram_wdata = wdata_i1;
                        stallreq        = go2;
                    end else if (go2) begin
                        data_sram_en    = 1'b1;
                        data_sram_wen   = wen_i2;
                        data_sram_addr  = addr_i2;
                        data_sram_wdata = wdata_i2;
                    end
                end
            end
            SECOND: begin
                // hold is deliberately ignored here: the pipeline is already frozen for i2.
                if (!rst && !flush) begin
                    data_sram_en    = 1'b1;
                    data_sram_wen   = buf_wen;
                    data_sram_addr  = buf_addr;
                    data_sram_wdata = buf_wdata;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pair_r    <= 1'b0;
            hold_r    <= '0;
            buf_wen   <= '0;
            buf_addr  <= '0;
            buf_wdata <= '0;
        end else begin
            pair_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (!flush && !hold && go1 && go2) begin
                        buf_wen   <= wen_i2;
                        buf_addr  <= addr_i2;
                        buf_wdata <= wdata_i2;
                        state     <= SECOND;
                    end
                end
                SECOND: begin
                    state <= IDLE;
                    if (!flush) begin
                        hold_r <= data_sram_rdata;
                        pair_r <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign rdata_i1 = pair_r ? hold_r : data_sram_rdata;
    assign rdata_i2 = data_sram_rdata;

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Self-checking bench for data_sram_arbiter: a table of single-cycle issue vectors
// plus hand-written multi-cycle sequences, with a small byte-write SRAM model.
module tb_data_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, hold;
    logic        req_i1, req_i2, ex_i1, ex_i2;
    logic [3:0]  wen_i1, wen_i2;
    logic [31:0] addr_i1, addr_i2, wdata_i1, wdata_i2;
    logic [31:0] sram_rdata = '0;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        stallreq;
    logic [31:0] rdata_i1, rdata_i2;

    logic [31:0] mem [0:1023];

    int errors = 0;
    int checks = 0;

    data_sram_arbiter #(.ADDR_WD(32), .DATA_WD(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold),
        .req_i1(req_i1), .req_i2(req_i2), .ex_i1(ex_i1), .ex_i2(ex_i2),
        .wen_i1(wen_i1), .wen_i2(wen_i2),
        .addr_i1(addr_i1), .addr_i2(addr_i2),
        .wdata_i1(wdata_i1), .wdata_i2(wdata_i2),
        .data_sram_rdata(sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .stallreq(stallreq), .rdata_i1(rdata_i1), .rdata_i2(rdata_i2)
    );

    always #5 clk = ~clk;

    // SRAM model: loads return data the cycle after en, stores write enabled bytes.
    always @(posedge clk) begin
        if (data_sram_en) begin
            if (data_sram_wen == 4'h0) begin
                sram_rdata <= mem[data_sram_addr[11:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (data_sram_wen[b])
                        mem[data_sram_addr[11:2]][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        string       name;
        logic        req1, req2, ex1, ex2, hld, fl;
        logic [3:0]  wen1, wen2;
        logic [31:0] addr1, addr2, wd1, wd2;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr, wdata;
        logic        stall;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input string n, input logic r1, r2, e1, e2, h, f,
                                input logic [3:0] w1, w2,
                                input logic en, input logic [3:0] w,
                                input logic [31:0] a, wd, input logic st);
        vec_t v;
        v.name = n; v.req1 = r1; v.req2 = r2; v.ex1 = e1; v.ex2 = e2; v.hld = h; v.fl = f;
        v.wen1 = w1; v.wen2 = w2;
        v.addr1 = 32'h0000_0100; v.addr2 = 32'h0000_0204;
        v.wd1 = 32'h1111_0001; v.wd2 = 32'h0000_CAFE;
        v.en = en; v.wen = w; v.addr = a; v.wdata = wd; v.stall = st;
        return v;
    endfunction

    function automatic logic [31:0] peek(input logic [31:0] a);
        return mem[a[11:2]];
    endfunction

    task automatic clearInputs();
        flush = 0; hold = 0; req_i1 = 0; req_i2 = 0; ex_i1 = 0; ex_i2 = 0;
        wen_i1 = 0; wen_i2 = 0; addr_i1 = 0; addr_i2 = 0; wdata_i1 = 0; wdata_i2 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        req_i1 = v.req1; req_i2 = v.req2; ex_i1 = v.ex1; ex_i2 = v.ex2;
        hold = v.hld; flush = v.fl;
        wen_i1 = v.wen1; wen_i2 = v.wen2; addr_i1 = v.addr1; addr_i2 = v.addr2;
        wdata_i1 = v.wd1; wdata_i2 = v.wd2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkPort(input string n, input logic en, input logic [3:0] w,
                             input logic [31:0] a, input logic [31:0] wd, input logic st);
        checkOutput({n, ".en"},    32'(data_sram_en),  32'(en));
        checkOutput({n, ".wen"},   32'(data_sram_wen), 32'(w));
        checkOutput({n, ".addr"},  data_sram_addr,     a);
        checkOutput({n, ".wdata"}, data_sram_wdata,    wd);
        checkOutput({n, ".stall"}, 32'(stallreq),      32'(st));
    endtask

    task automatic doStore(input logic [31:0] a, input logic [31:0] d);
        tick();
        clearInputs();
        req_i1 = 1; wen_i1 = 4'hF; addr_i1 = a; wdata_i1 = d;
        tick();
        clearInputs();
    endtask

    task automatic pairFlushOrReset(input string n, input logic use_rst,
                                    input logic [31:0] a2, input logic [31:0] keep);
        tick();
        clearInputs();
        req_i1 = 1; addr_i1 = 32'h300;
        req_i2 = 1; wen_i2 = 4'hF; addr_i2 = a2; wdata_i2 = 32'hDEAD_BEEF;
        @(negedge clk);
        checkPort({n, "_T"}, 1, 4'h0, 32'h300, 32'h0, 1);
        tick();
        if (use_rst) rst = 1; else flush = 1;
        @(negedge clk);
        checkPort({n, "_T1"}, 0, 4'h0, 32'h0, 32'h0, 0);
        tick();
        rst = 0;
        clearInputs();
        @(negedge clk);
        checkOutput({n, "_T2.rdata_i1"}, rdata_i1, 32'h0000_0033);
        checkOutput({n, "_T2.en"}, 32'(data_sram_en), 32'h0);
        checkOutput({n, "_no_store"}, peek(a2), keep);
        // A fresh single access must be accepted straight away from IDLE.
        req_i1 = 1; addr_i1 = 32'h104;
        @(negedge clk);
        checkPort({n, "_after"}, 1, 4'h0, 32'h104, 32'h0, 0);
    endtask

    initial begin
        clearInputs();
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checkPort("reset", 0, 4'h0, 32'h0, 32'h0, 0);
        checkOutput("reset.rdata_i1", rdata_i1, 32'h0);
        checkOutput("reset.rdata_i2", rdata_i2, 32'h0);

        doStore(32'h100, 32'hAAAA_0001);
        doStore(32'h104, 32'hBBBB_0002);
        doStore(32'h300, 32'h0000_0033);
        doStore(32'h304, 32'h0000_0044);
        doStore(32'h308, 32'h0000_0088);

        vecs[0]  = mk("v_i1_only",    1,0,0,0,0,0, 4'h0,4'h0, 1,4'h0,32'h100,32'h1111_0001,0);
        vecs[1]  = mk("v_i2_only",    0,1,0,0,0,0, 4'h0,4'h3, 1,4'h3,32'h204,32'h0000_CAFE,0);
        vecs[2]  = mk("v_pair_ex1",   1,1,1,0,0,0, 4'h0,4'h0, 0,4'h0,32'h0,32'h0,0);
        vecs[3]  = mk("v_pair_ex2",   1,1,0,1,0,0, 4'h0,4'h0, 1,4'h0,32'h100,32'h1111_0001,0);
        vecs[4]  = mk("v_i1_ex1",     1,0,1,0,0,0, 4'h0,4'h0, 0,4'h0,32'h0,32'h0,0);
        vecs[5]  = mk("v_i2_killed",  0,1,1,0,0,0, 4'h0,4'h0, 0,4'h0,32'h0,32'h0,0);
        vecs[6]  = mk("v_pair_hold",  1,1,0,0,1,0, 4'h0,4'h0, 0,4'h0,32'h0,32'h0,0);
        vecs[7]  = mk("v_pair_flush", 1,1,0,0,0,1, 4'h0,4'h0, 0,4'h0,32'h0,32'h0,0);
        vecs[8]  = mk("v_i1_hold",    1,0,0,0,1,0, 4'h0,4'h0, 0,4'h0,32'h0,32'h0,0);
        vecs[9]  = mk("v_i2_flush",   0,1,0,0,0,1, 4'h0,4'h0, 0,4'h0,32'h0,32'h0,0);
        vecs[10] = mk("v_pair",       1,1,0,0,0,0, 4'h0,4'h0, 1,4'h0,32'h100,32'h1111_0001,1);

        foreach (vecs[i]) begin
            tick();
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkPort(vecs[i].name, vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].stall);
            tick();
            clearInputs();
        end
        tick();

        // Single load: data for i1 appears the next cycle.
        tick();
        req_i1 = 1; addr_i1 = 32'h100;
        @(negedge clk);
        checkPort("single_T", 1, 4'h0, 32'h100, 32'h0, 0);
        tick();
        clearInputs();
        @(negedge clk);
        checkOutput("single_T1.rdata_i1", rdata_i1, 32'hAAAA_0001);

        // Two loads serialised; the pipeline holds the inputs during the stall.
        tick();
        req_i1 = 1; addr_i1 = 32'h100; req_i2 = 1; addr_i2 = 32'h104;
        @(negedge clk);
        checkPort("pair_T", 1, 4'h0, 32'h100, 32'h0, 1);
        tick();
        @(negedge clk);
        checkPort("pair_T1", 1, 4'h0, 32'h104, 32'h0, 0);
        tick();
        clearInputs();
        @(negedge clk);
        checkOutput("pair_T2.rdata_i1", rdata_i1, 32'hAAAA_0001);
        checkOutput("pair_T2.rdata_i2", rdata_i2, 32'hBBBB_0002);
        tick();
        @(negedge clk);
        checkOutput("pair_T3.rdata_i1", rdata_i1, 32'hBBBB_0002);

        // Store in i1 then load of the same address in i2.
        tick();
        req_i1 = 1; wen_i1 = 4'hF; addr_i1 = 32'h200; wdata_i1 = 32'h1234_5678;
        req_i2 = 1; addr_i2 = 32'h200;
        @(negedge clk);
        checkPort("st_ld_T", 1, 4'hF, 32'h200, 32'h1234_5678, 1);
        tick();
        @(negedge clk);
        checkPort("st_ld_T1", 1, 4'h0, 32'h200, 32'h0, 0);
        tick();
        clearInputs();
        @(negedge clk);
        checkOutput("st_ld_T2.rdata_i2", rdata_i2, 32'h1234_5678);

        pairFlushOrReset("flush2nd", 0, 32'h304, 32'h0000_0044);
        pairFlushOrReset("rst2nd",   1, 32'h308, 32'h0000_0088);

        // hold blocks a pair in IDLE; releasing it gives the normal pair sequence.
        tick();
        clearInputs();
        req_i1 = 1; addr_i1 = 32'h100; req_i2 = 1; addr_i2 = 32'h104; hold = 1;
        @(negedge clk);
        checkPort("hold_T", 0, 4'h0, 32'h0, 32'h0, 0);
        tick();
        hold = 0;
        @(negedge clk);
        checkPort("hold_rel_T", 1, 4'h0, 32'h100, 32'h0, 1);
        tick();
        @(negedge clk);
        checkPort("hold_rel_T1", 1, 4'h0, 32'h104, 32'h0, 0);
        tick();
        clearInputs();
        @(negedge clk);
        checkOutput("hold_rel_T2.rdata_i1", rdata_i1, 32'hAAAA_0001);
        checkOutput("hold_rel_T2.rdata_i2", rdata_i2, 32'hBBBB_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
